// File: rtl/bist_response_compactor.sv
// -----------------------------------------------------------------------------
// bist_response_compactor
//
// Purpose:
//    Response side of a built-in self-test loop. Each cycle the circuit under
//    test presents an output vector on D. Every vector qualified by VLD is
//    folded into a multiple-input signature register (MISR). When NPAT vectors
//    have been taken, the signature is compared once against GOLD, and the
//    verdict is reported on PASS while DONE is high.
//
// Ports:
//    CK     in   1   clock, rising edge
//    RST    in   1   asynchronous active-high reset
//    START  in   1   begin a run (honoured in IDLE or DONE only)
//    ABORT  in   1   cancel any activity and return to IDLE (highest priority)
//    NPAT   in   CW  number of response vectors to compact (sampled on START)
//    GOLD   in   W   expected signature (sampled in the compare cycle)
//    VLD    in   1   D carries a valid response this cycle
//    D      in   W   response vector from the circuit under test
//    BUSY   out  1   high while a run or the compare cycle is in progress
//    DONE   out  1   high in the DONE state
//    PASS   out  1   signature matched GOLD (meaningful while DONE=1)
//    SIG    out  W   current signature register
//    CNT    out  CW  vectors compacted so far in this run
//
// Every output is either a register or a decode of the state register, so
// D and VLD have no combinational path to the outputs.
// -----------------------------------------------------------------------------
module bist_response_compactor #(
   parameter int           W    = 6,
   parameter logic [W-1:0] POLY = 6'h03,
   parameter logic [W-1:0] SEED = '0,
   parameter int           CW   = 16
) (
   input  logic          CK,
   input  logic          RST,
   input  logic          START,
   input  logic          ABORT,
   input  logic [CW-1:0] NPAT,
   input  logic [W-1:0]  GOLD,
   input  logic          VLD,
   input  logic [W-1:0]  D,
   output logic          BUSY,
   output logic          DONE,
   output logic          PASS,
   output logic [W-1:0]  SIG,
   output logic [CW-1:0] CNT
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CMP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  sig_q,   sig_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [CW-1:0] npat_q,  npat_d;
   logic          pass_q,  pass_d;

   // --------------------------------------------------------------------------
   // MISR step: shift left by one, fold the bit shifted out back in through
   // the feedback polynomial (x^W implicit), then XOR the incoming response.
   // Built bit by bit so each tap is an explicit two- or three-input XOR.
   // --------------------------------------------------------------------------
   logic [W-1:0] misr_next;
   logic         fb;

   assign fb = sig_q[W-1];

   genvar gi;
   generate
      for (gi = 0; gi < W; gi = gi + 1) begin : g_misr
         if (gi == 0) begin : g_lsb
            // Bit 0 has no lower neighbour to shift in from.
            assign misr_next[gi] = (fb & POLY[gi]) ^ D[gi];
         end else begin : g_upper
            assign misr_next[gi] = sig_q[gi-1] ^ (fb & POLY[gi]) ^ D[gi];
         end
      end
   endgenerate

   // Final vector of the run: the counter is one short of the latched target.
   // Only meaningful in RUN, where the latched target is always at least one.
   logic last_vec;
   assign last_vec = (cnt_q == (npat_q - CW'(1)));

   // --------------------------------------------------------------------------
   // State register and datapath registers
   // --------------------------------------------------------------------------
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         sig_q   <= SEED;
         cnt_q   <= '0;
         npat_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         npat_q  <= npat_d;
         pass_q  <= pass_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and datapath control
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      npat_d  = npat_q;
      pass_d  = pass_q;

      if (ABORT) begin
         // Abandon the run but keep SIG/CNT visible for post-mortem inspection.
         state_d = ST_IDLE;
         pass_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (START) begin
                  sig_d  = SEED;
                  cnt_d  = '0;
                  npat_d = NPAT;
                  pass_d = 1'b0;
                  // An empty run has nothing to compact; compare the seed.
                  state_d = (NPAT == '0) ? ST_CMP : ST_RUN;
               end
            end

            ST_RUN: begin
               // VLD low is a stall: nothing moves and there is no timeout.
               if (VLD) begin
                  sig_d = misr_next;
                  cnt_d = cnt_q + CW'(1);
                  if (last_vec) begin
                     state_d = ST_CMP;
                  end
               end
            end

            ST_CMP: begin
               // Single compare cycle; VLD/D are deliberately ignored here.
               pass_d  = (sig_q == GOLD);
               state_d = ST_DONE;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign BUSY = (state_q == ST_RUN) || (state_q == ST_CMP);
   assign DONE = (state_q == ST_DONE);
   assign PASS = pass_q;
   assign SIG  = sig_q;
   assign CNT  = cnt_q;

endmodule

// File: tb/tb_bist_response_compactor.sv
// -----------------------------------------------------------------------------
// tb_bist_response_compactor
//
// Self-checking bench for bist_response_compactor. Every accepted response
// vector pushes its expected signature onto a scoreboard queue; the entry is
// popped and compared once the DUT has registered the vector.
// -----------------------------------------------------------------------------
module tb_bist_response_compactor;

   localparam int           W    = 6;
   localparam logic [W-1:0] POLY = 6'h03;
   localparam logic [W-1:0] SEED = 6'h00;
   localparam int           CW   = 16;

   logic          CK;
   logic          RST;
   logic          START;
   logic          ABORT;
   logic [CW-1:0] NPAT;
   logic [W-1:0]  GOLD;
   logic          VLD;
   logic [W-1:0]  D;
   logic          BUSY;
   logic          DONE;
   logic          PASS;
   logic [W-1:0]  SIG;
   logic [CW-1:0] CNT;

   int n_checks;
   int n_errors;

   logic [W-1:0]  model_sig;
   logic [CW-1:0] model_cnt;
   logic [W-1:0]  exp_q[$];

   bist_response_compactor #(
      .W    (W),
      .POLY (POLY),
      .SEED (SEED),
      .CW   (CW)
   ) dut (
      .CK    (CK),
      .RST   (RST),
      .START (START),
      .ABORT (ABORT),
      .NPAT  (NPAT),
      .GOLD  (GOLD),
      .VLD   (VLD),
      .D     (D),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .PASS  (PASS),
      .SIG   (SIG),
      .CNT   (CNT)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // Reference MISR step, written from the recurrence rather than bit taps.
   function automatic logic [W-1:0] misr_ref(input logic [W-1:0] s, input logic [W-1:0] v);
      logic [W-1:0] shifted;
      shifted = s << 1;
      if (s[W-1]) shifted = shifted ^ POLY;
      return shifted ^ v;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Sample 1 time unit after the rising edge; inputs are driven from here too.
   task automatic tick;
      @(posedge CK);
      #1;
   endtask

   task automatic do_start(input logic [CW-1:0] n);
      START = 1'b1;
      NPAT  = n;
      tick();
      START = 1'b0;
      check_val("start_done", DONE, 0);
      check_val("start_pass", PASS, 0);
      check_val("start_sig",  SIG,  SEED);
      check_val("start_cnt",  CNT,  0);
      check_val("start_busy", BUSY, 1);
      model_sig = SEED;
      model_cnt = '0;
   endtask

   task automatic send(input logic [W-1:0] v, input int stall);
      logic [W-1:0] exp_sig;
      for (int i = 0; i < stall; i++) begin
         VLD = 1'b0;
         D   = W'($urandom);
         tick();
         check_val("stall_busy", BUSY, 1);
         check_val("stall_sig",  SIG,  model_sig);
      end
      VLD = 1'b1;
      D   = v;
      model_sig = misr_ref(model_sig, v);
      model_cnt = model_cnt + 1'b1;
      exp_q.push_back(model_sig);
      tick();
      VLD = 1'b0;
      exp_sig = exp_q.pop_front();
      check_val("sig", SIG, exp_sig);
      check_val("cnt", CNT, model_cnt);
   endtask

   // Called in the cycle after the last vector edge (the compare cycle).
   task automatic finish_run(input logic [W-1:0] gold, input logic exp_pass);
      logic [W-1:0] held;
      GOLD = gold;
      check_val("cmp_busy", BUSY, 1);
      check_val("cmp_done", DONE, 0);
      VLD = 1'b1;                 // must be ignored in the compare cycle
      D   = 6'h2A;
      tick();
      check_val("done",      DONE, 1);
      check_val("done_busy", BUSY, 0);
      check_val("pass",      PASS, exp_pass);
      check_val("final_sig", SIG,  model_sig);
      check_val("final_cnt", CNT,  model_cnt);
      held = SIG;
      tick();                     // DONE holds everything, even with VLD high
      VLD = 1'b0;
      check_val("hold_done", DONE, 1);
      check_val("hold_sig",  SIG,  held);
      check_val("hold_pass", PASS, exp_pass);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      RST   = 1'b1;
      START = 1'b0;
      ABORT = 1'b0;
      NPAT  = '0;
      GOLD  = '0;
      VLD   = 1'b0;
      D     = '0;
      model_sig = SEED;
      model_cnt = '0;
      tick();
      tick();
      RST = 1'b0;
      tick();

      check_val("rst_sig",  SIG,  6'h00);
      check_val("rst_cnt",  CNT,  0);
      check_val("rst_busy", BUSY, 0);
      check_val("rst_done", DONE, 0);
      check_val("rst_pass", PASS, 0);

      // Basic run, matching golden signature.
      do_start(16'd3);
      send(6'h3F, 0);
      check_val("sig_3f", SIG, 6'h3F);
      send(6'h00, 0);
      check_val("sig_3d", SIG, 6'h3D);
      send(6'h00, 0);
      check_val("sig_39", SIG, 6'h39);
      finish_run(6'h39, 1'b1);

      // Same run, wrong golden value (also restarts from DONE).
      do_start(16'd3);
      send(6'h3F, 0);
      send(6'h00, 0);
      send(6'h00, 0);
      finish_run(6'h38, 1'b0);

      // Stalls between vectors.
      do_start(16'd3);
      send(6'h3F, 0);
      send(6'h00, 4);
      send(6'h00, 4);
      check_val("stall_sig_39", SIG, 6'h39);
      finish_run(6'h39, 1'b1);

      // Empty run: RUN is skipped, seed compared.
      do_start(16'd0);
      finish_run(6'h00, 1'b1);

      // ABORT with START during RUN.
      do_start(16'd3);
      send(6'h3F, 0);
      ABORT = 1'b1;
      START = 1'b1;
      VLD   = 1'b1;
      D     = 6'h15;
      tick();
      ABORT = 1'b0;
      START = 1'b0;
      VLD   = 1'b0;
      check_val("abort_busy", BUSY, 0);
      check_val("abort_done", DONE, 0);
      check_val("abort_sig",  SIG,  6'h3F);
      check_val("abort_cnt",  CNT,  1);
      tick();
      check_val("idle_sig",   SIG,  6'h3F);
      do_start(16'd2);
      send(6'h05, 0);
      send(6'h22, 0);
      finish_run(misr_ref(misr_ref(SEED, 6'h05), 6'h22), 1'b1);

      // Restart from DONE with PASS previously high.
      do_start(16'd1);
      send(6'h01, 0);
      check_val("restart_sig", SIG, 6'h01);
      finish_run(6'h01, 1'b1);

      // Asynchronous reset in the middle of a run.
      do_start(16'd5);
      send(6'h3F, 0);
      send(6'h11, 0);
      @(posedge CK);
      #2;
      RST = 1'b1;
      #1;
      check_val("arst_sig",  SIG,  6'h00);
      check_val("arst_cnt",  CNT,  0);
      check_val("arst_busy", BUSY, 0);
      check_val("arst_done", DONE, 0);
      check_val("arst_pass", PASS, 0);
      tick();
      RST = 1'b0;
      tick();
      check_val("post_rst_busy", BUSY, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Hard upper bound on run time.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
